// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared by the SDRAM request queue and the SDRAM
// controller.
//   - Default address-field widths for a 32 MB x16 part.
//   - Default depth of the request FIFO.
//   - Width of the host/controller data bus.
//   - The issue-FSM state type.
//   - issue_enables(): decodes the controller strobes from an FSM state.
package sdram_pkg;

    localparam int SDRAM_ROW_WIDTH  = 13;
    localparam int SDRAM_COL_WIDTH  = 9;
    localparam int SDRAM_BANK_WIDTH = 2;
    localparam int SDRAM_DATA_WIDTH = 16;
    localparam int REQ_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Returns {rd_enable, wr_enable}.
    // A strobe is asserted only while the FSM is in S_ISSUE.
    function automatic logic [1:0] issue_enables(input state_t st, input logic is_write);
        logic [1:0] en;
        case (st)
            S_ISSUE: en = is_write ? 2'b01 : 2'b10;
            default: en = 2'b00;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo: synchronous FIFO that holds the pending host requests.
//
// Pointers carry one extra wrap bit, which tells full apart from empty.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   push, push_data write an entry; ignored while the FIFO is full
//   pop             drop the head entry; ignored while the FIFO is empty
//   head            the current head entry (valid when empty=0)
//   full, empty     occupancy flags, decoded from the registered pointers
//   level           number of stored entries
module sdram_req_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                       (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer registers. Each pointer wraps naturally through its extra bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Entry storage. It needs no reset because the pointers gate all reads.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/sdram_req_queue.sv
// sdram_req_queue: buffers host read/write requests and hands them to the
// SDRAM controller one at a time. At most one operation is outstanding.
//
// Host side:
//   req_valid/req_ready  handshake that pushes a request
//   req_write, req_addr, req_wdata  the request fields
//   resp_valid, resp_data           read data, returned one cycle after rd_ready
// Controller side:
//   rd_addr, rd_enable              read command
//   wr_addr, wr_data, wr_enable     write command
//   rd_data, rd_ready               read data return
//   busy                            controller accepted or is running an operation
// Status:
//   level  FIFO occupancy
//   idle   FIFO empty and nothing in flight
module sdram_req_queue
    import sdram_pkg::*;
#(
    parameter int ROW_WIDTH   = SDRAM_ROW_WIDTH,
    parameter int COL_WIDTH   = SDRAM_COL_WIDTH,
    parameter int BANK_WIDTH  = SDRAM_BANK_WIDTH,
    parameter int HADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH,
    parameter int FIFO_DEPTH  = REQ_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [HADDR_WIDTH-1:0]        req_addr,
    input  logic [15:0]                   req_wdata,
    output logic                          resp_valid,
    output logic [15:0]                   resp_data,
    output logic [HADDR_WIDTH-1:0]        rd_addr,
    output logic                          rd_enable,
    output logic [HADDR_WIDTH-1:0]        wr_addr,
    output logic [15:0]                   wr_data,
    output logic                          wr_enable,
    input  logic [15:0]                   rd_data,
    input  logic                          rd_ready,
    input  logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
    ,
    output logic                          idle
);

    localparam int ENTRY_W = 1 + HADDR_WIDTH + SDRAM_DATA_WIDTH;

    logic [ENTRY_W-1:0]      head_s;
    logic                    head_write_s;
    logic [HADDR_WIDTH-1:0]  head_addr_s;
    logic [15:0]             head_data_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    capture_s;
    logic [1:0]              enables_next_s;

    state_t                  state_r;
    state_t                  state_next_s;
    logic                    issue_write_r;
    logic                    issue_write_next_s;
    logic                    rd_enable_r;
    logic                    wr_enable_r;
    logic                    resp_valid_r;
    logic [15:0]             resp_data_r;

    assign push_s = req_valid && !full_s;
    // The controller accepts the command when busy rises, so the head is popped then.
    assign pop_s  = (state_r == S_ISSUE) && busy;
    // rd_ready only matters while a read is outstanding.
    assign capture_s = (state_r == S_WAIT) && !issue_write_r && rd_ready;

    sdram_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data ({req_write, req_addr, req_wdata}),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (level)
    );

    assign head_write_s = head_s[ENTRY_W-1];
    assign head_addr_s  = head_s[ENTRY_W-2:SDRAM_DATA_WIDTH];
    assign head_data_s  = head_s[SDRAM_DATA_WIDTH-1:0];

    // The head cannot change during S_ISSUE because nothing is popped until busy rises.
    assign rd_addr    = head_addr_s;
    assign wr_addr    = head_addr_s;
    assign wr_data    = head_data_s;
    assign req_ready  = !full_s;
    assign rd_enable  = rd_enable_r;
    assign wr_enable  = wr_enable_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign idle       = empty_s && (state_r == S_IDLE);

    // Next-state logic. The operation type is latched when the FSM leaves S_IDLE.
    always_comb begin
        state_next_s       = state_r;
        issue_write_next_s = issue_write_r;
        case (state_r)
            S_IDLE: begin
                if (!empty_s && !busy) begin
                    state_next_s       = S_ISSUE;
                    issue_write_next_s = head_write_s;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                // There is no timeout; a refresh may hold off acceptance indefinitely.
                if (busy) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (issue_write_r) begin
                    if (!busy) begin
                        state_next_s = S_IDLE;
                    end else begin
                        state_next_s = S_WAIT;
                    end
                end else begin
                    if (rd_ready) begin
                        state_next_s = S_IDLE;
                    end else begin
                        state_next_s = S_WAIT;
                    end
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
        enables_next_s = issue_enables(state_next_s, issue_write_next_s);
    end

    // FSM state, latched operation type and registered command strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            issue_write_r <= 1'b0;
            rd_enable_r   <= 1'b0;
            wr_enable_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            issue_write_r <= issue_write_next_s;
            rd_enable_r   <= enables_next_s[1];
            wr_enable_r   <= enables_next_s[0];
        end
    end

    // Read response register. resp_data keeps the last returned word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= 16'h0000;
        end else begin
            resp_valid_r <= capture_s;
            if (capture_s) begin
                resp_data_r <= rd_data;
            end else begin
                resp_data_r <= resp_data_r;
            end
        end
    end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Self-checking bench for sdram_req_queue.
//
// A transaction-level reference model tracks the following state:
//   - the ordered list of accepted requests;
//   - whether a command is being offered;
//   - whether an operation is outstanding;
//   - the pending read response.
// Every cycle the outputs are compared against this model. Directed
// scenarios run first, then a randomized phase.
module tb_sdram_req_queue;

    localparam int HW    = 24;
    localparam int DEPTH = 4;

    typedef struct {
        logic          w;
        logic [HW-1:0] a;
        logic [15:0]   d;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [HW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic          resp_valid;
    logic [15:0]   resp_data;
    logic [HW-1:0] rd_addr;
    logic          rd_enable;
    logic [HW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_enable;
    logic [15:0]   rd_data;
    logic          rd_ready;
    logic          busy;
    logic [2:0]    level;
    logic          idle;

    always #5 clk = ~clk;

    sdram_req_queue #(
        .ROW_WIDTH  (13),
        .COL_WIDTH  (9),
        .BANK_WIDTH (2),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .rd_addr    (rd_addr),
        .rd_enable  (rd_enable),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_enable  (wr_enable),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .busy       (busy),
        .level      (level),
        .idle       (idle)
    );

    // Reference model state.
    req_t        q[$];
    bit          m_iss;
    bit          m_wait;
    bit          m_wait_wr;
    bit          m_rv;
    logic [15:0] m_rd;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the outputs against the model, advances the model for the
    // current inputs, then moves past the next rising edge.
    task automatic cyc();
        bit          push;
        bit          n_rv;
        logic [15:0] n_rd;
        req_t        e;
        logic        exp_rd_en;
        logic        exp_wr_en;

        exp_rd_en = 1'b0;
        exp_wr_en = 1'b0;
        if (m_iss && q.size() > 0) begin
            exp_rd_en = !q[0].w;
            exp_wr_en = q[0].w;
        end
        chk("req_ready", {31'd0, req_ready}, {31'd0, q.size() < DEPTH});
        chk("level", {29'd0, level}, q.size());
        chk("rd_enable", {31'd0, rd_enable}, {31'd0, exp_rd_en});
        chk("wr_enable", {31'd0, wr_enable}, {31'd0, exp_wr_en});
        chk("idle", {31'd0, idle}, {31'd0, (q.size() == 0) && !m_iss && !m_wait});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_rv});
        chk("resp_data", {16'd0, resp_data}, {16'd0, m_rd});
        if (q.size() > 0) begin
            chk("rd_addr", {8'd0, rd_addr}, {8'd0, q[0].a});
            chk("wr_addr", {8'd0, wr_addr}, {8'd0, q[0].a});
            chk("wr_data", {16'd0, wr_data}, {16'd0, q[0].d});
        end

        push = req_valid && (q.size() < DEPTH);
        n_rv = 1'b0;
        n_rd = m_rd;
        if (m_iss) begin
            if (busy) begin
                e         = q.pop_front();
                m_iss     = 1'b0;
                m_wait    = 1'b1;
                m_wait_wr = e.w;
            end
        end else if (m_wait) begin
            if (m_wait_wr) begin
                if (!busy) m_wait = 1'b0;
            end else if (rd_ready) begin
                m_wait = 1'b0;
                n_rv   = 1'b1;
                n_rd   = rd_data;
            end
        end else if (q.size() != 0 && !busy) begin
            m_iss = 1'b1;
        end
        if (push) begin
            e = '{req_write, req_addr, req_wdata};
            q.push_back(e);
        end
        if (!rst_n) begin
            q.delete();
            m_iss  = 1'b0;
            m_wait = 1'b0;
            n_rv   = 1'b0;
            n_rd   = 16'h0000;
        end
        m_rv = n_rv;
        m_rd = n_rd;
        @(posedge clk);
        #1;
    endtask

    // Lets the controller side run randomly until the model has nothing
    // queued or in flight. The loop is bounded.
    task automatic drain(input string tag);
        bit done;
        done      = (q.size() == 0) && !m_iss && !m_wait;
        req_valid = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            busy     = 1'($urandom_range(0, 1));
            rd_ready = 1'($urandom_range(0, 1));
            rd_data  = 16'($urandom);
            cyc();
            done = (q.size() == 0) && !m_iss && !m_wait;
        end
        busy     = 1'b0;
        rd_ready = 1'b0;
        chk(tag, {31'd0, idle}, 32'd1);
    endtask

    task automatic set_req(input logic v, input logic w, input logic [HW-1:0] a, input logic [15:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    logic [HW-1:0] hold_addr;

    initial begin
        rst_n     = 1'b0;
        busy      = 1'b0;
        rd_ready  = 1'b0;
        rd_data   = 16'h0000;
        set_req(1'b0, 1'b0, 24'h0, 16'h0);
        q.delete();
        m_iss  = 1'b0;
        m_wait = 1'b0;
        m_rv   = 1'b0;
        m_rd   = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_data", {16'd0, resp_data}, 32'd0);
        cyc();

        // Scenario: single write.
        set_req(1'b1, 1'b1, 24'h012345, 16'hA5A5);
        cyc();
        set_req(1'b0, 1'b0, 24'h0, 16'h0);
        cyc();
        chk("w1_wr_enable", {31'd0, wr_enable}, 32'd1);
        chk("w1_wr_addr", {8'd0, wr_addr}, 32'h012345);
        chk("w1_wr_data", {16'd0, wr_data}, 32'h0000A5A5);
        cyc();
        chk("w1_hold", {31'd0, wr_enable}, 32'd1);
        busy = 1'b1;
        cyc();
        chk("w1_drop", {31'd0, wr_enable}, 32'd0);
        busy = 1'b0;
        cyc();
        chk("w1_idle", {31'd0, idle}, 32'd1);

        // Scenario: single read, one-cycle response latency.
        set_req(1'b1, 1'b0, 24'h000010, 16'h0);
        cyc();
        set_req(1'b0, 1'b0, 24'h0, 16'h0);
        cyc();
        chk("r1_rd_enable", {31'd0, rd_enable}, 32'd1);
        chk("r1_rd_addr", {8'd0, rd_addr}, 32'h000010);
        busy = 1'b1;
        cyc();
        chk("r1_rd_drop", {31'd0, rd_enable}, 32'd0);
        busy     = 1'b0;
        rd_ready = 1'b1;
        rd_data  = 16'h1234;
        chk("r1_no_early_resp", {31'd0, resp_valid}, 32'd0);
        cyc();
        rd_ready = 1'b0;
        chk("r1_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("r1_resp_data", {16'd0, resp_data}, 32'h1234);
        cyc();
        chk("r1_resp_pulse", {31'd0, resp_valid}, 32'd0);

        // Scenario: fill the FIFO while busy is high; the fifth request waits.
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 1'b0, 24'(24'h100 + i), 16'h0);
            cyc();
        end
        set_req(1'b1, 1'b0, 24'h000104, 16'h0);
        chk("full_ready", {31'd0, req_ready}, 32'd0);
        chk("full_level", {29'd0, level}, 32'd4);
        cyc();
        chk("full_hold_level", {29'd0, level}, 32'd4);
        busy = 1'b0;
        cyc();
        busy = 1'b1;
        cyc();
        chk("full_pop_no_push", {29'd0, level}, 32'd3);
        cyc();
        set_req(1'b0, 1'b0, 24'h0, 16'h0);
        chk("full_fifth_in", {29'd0, level}, 32'd4);
        drain("full_drain");

        // Scenario: simultaneous push and pop at level 2.
        busy = 1'b1;
        set_req(1'b1, 1'b0, 24'h000200, 16'h0);
        cyc();
        set_req(1'b1, 1'b0, 24'h000201, 16'h0);
        cyc();
        set_req(1'b0, 1'b0, 24'h0, 16'h0);
        busy = 1'b0;
        cyc();
        chk("pp_level_before", {29'd0, level}, 32'd2);
        busy = 1'b1;
        set_req(1'b1, 1'b0, 24'h000202, 16'h0);
        cyc();
        set_req(1'b0, 1'b0, 24'h0, 16'h0);
        chk("pp_level_after", {29'd0, level}, 32'd2);
        drain("pp_drain");

        // Scenario: refresh holds busy low for 20 cycles while a read is offered.
        set_req(1'b1, 1'b0, 24'h0ABCDE, 16'h0);
        cyc();
        set_req(1'b0, 1'b0, 24'h0, 16'h0);
        cyc();
        hold_addr = 24'h0ABCDE;
        for (int i = 0; i < 20; i++) begin
            chk("ref_rd_enable", {31'd0, rd_enable}, 32'd1);
            chk("ref_addr", {8'd0, rd_addr}, {8'd0, hold_addr});
            chk("ref_level", {29'd0, level}, 32'd1);
            cyc();
        end
        busy = 1'b1;
        cyc();
        chk("ref_popped", {29'd0, level}, 32'd0);
        drain("ref_drain");

        // Scenario: reset while a read is outstanding and 3 requests are queued.
        set_req(1'b1, 1'b0, 24'h000300, 16'h0);
        cyc();
        set_req(1'b1, 1'b0, 24'h000301, 16'h0);
        cyc();
        busy = 1'b1;
        set_req(1'b1, 1'b0, 24'h000302, 16'h0);
        cyc();
        set_req(1'b1, 1'b1, 24'h000303, 16'h5555);
        cyc();
        set_req(1'b0, 1'b0, 24'h0, 16'h0);
        chk("rst_mid_level_before", {29'd0, level}, 32'd3);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_mid_level", {29'd0, level}, 32'd0);
        chk("rst_mid_rd_enable", {31'd0, rd_enable}, 32'd0);
        rd_ready = 1'b1;
        rd_data  = 16'hDEAD;
        cyc();
        rd_ready = 1'b0;
        chk("rst_mid_no_resp", {31'd0, resp_valid}, 32'd0);
        busy = 1'b0;
        cyc();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    24'($urandom), 16'($urandom));
            busy     = 1'($urandom_range(0, 1));
            rd_ready = 1'($urandom_range(0, 1));
            rd_data  = 16'($urandom);
            rst_n    = ($urandom_range(0, 99) != 0);
            cyc();
        end
        rst_n = 1'b1;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
